// File: rtl/mem_pkg.sv
// mem_pkg: shared state/port encodings and default timeout for the memory arbiter
package mem_pkg;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction port, data port and shared memory bus of the arbiter
interface mem_arbiter_if;
  logic        i_req, i_wait, i_err;
  logic [31:0] i_addr, i_data;
  logic        d_req, d_we, d_wait, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        bus_rd, bus_wr, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_ready, bus_rdata,
    output i_wait, i_data, i_err, d_wait, d_rdata, d_err, bus_addr, bus_wdata, bus_rd, bus_wr
  );
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_ready, bus_rdata,
    input  i_wait, i_data, i_err, d_wait, d_rdata, d_err, bus_addr, bus_wdata, bus_rd, bus_wr
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, one-hot grant {d, i}
module rr_pick2
  import mem_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  port_t      last,
  output logic [1:0] gnt
);
  assign gnt = (req_i & req_d) ? (last == PORT_D ? 2'b01 : 2'b10) : {req_d, req_i};
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction and data ports,
// round-robin on contention, with a busy-cycle timeout that aborts stuck transfers.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic Nrst,
  mem_arbiter_if.master m
);
  state_t     state;
  port_t      last;
  logic [7:0] cnt;
  logic [1:0] gnt;
  logic       timeout, done, i_own, d_own;
  rr_pick2 u_pick (.req_i(m.i_req), .req_d(m.d_req), .last(last), .gnt(gnt));
  assign timeout  = cnt == 8'(TIMEOUT - 1);
  assign i_own    = state == I_BUSY;
  assign d_own    = state == D_BUSY;
  assign done     = (i_own | d_own) & (m.bus_ready | timeout);
  // a ready on the timeout cycle wins, so err only flags a true abort
  assign m.i_wait = m.i_req & ~(i_own & done);
  assign m.i_err  = i_own & done & ~m.bus_ready;
  assign m.i_data = (i_own & m.bus_ready) ? m.bus_rdata : '0;
  assign m.d_wait = m.d_req & ~(d_own & done);
  assign m.d_err  = d_own & done & ~m.bus_ready;
  assign m.d_rdata = (d_own & m.bus_ready) ? m.bus_rdata : '0;
  always_ff @(posedge clk or negedge Nrst)
    if (!Nrst) begin
      state       <= IDLE;
      last        <= PORT_D;
      cnt         <= '0;
      m.bus_addr  <= '0;
      m.bus_wdata <= '0;
      m.bus_rd    <= 1'b0;
      m.bus_wr    <= 1'b0;
    end else if (state == IDLE) begin
      if (|gnt) begin
        state       <= gnt[0] ? I_BUSY : D_BUSY;
        last        <= gnt[0] ? PORT_I : PORT_D;
        cnt         <= '0;
        m.bus_addr  <= gnt[0] ? m.i_addr : m.d_addr;
        m.bus_wdata <= gnt[0] ? '0 : m.d_wdata;
        m.bus_rd    <= gnt[0] | ~m.d_we;
        m.bus_wr    <= gnt[1] & m.d_we;
      end
    end else if (done) begin
      state    <= IDLE;
      m.bus_rd <= 1'b0;
      m.bus_wr <= 1'b0;
    end else begin
      cnt <= cnt + 8'd1;
    end
endmodule
